// File: rtl/instr_sequencer_if.sv
// Control-unit/memory-side signal bundle of the instruction sequencer.
// The master drives instruction status and requests; the slave is the sequencer.
interface instr_sequencer_if;
  logic [1:0]  wait_cycle;
  logic        werf_in;
  logic        wedmem_in;
  logic        imem_ack;
  logic        halt_req;
  logic        imem_req;
  logic        ir_load;
  logic        pc_en;
  logic        werf_out;
  logic        wedmem_out;
  logic        instr_done;
  logic        halted;
  logic [15:0] retired;

  modport master (
    output wait_cycle, werf_in, wedmem_in, imem_ack, halt_req,
    input  imem_req, ir_load, pc_en, werf_out, wedmem_out, instr_done, halted, retired
  );

  modport slave (
    input  wait_cycle, werf_in, wedmem_in, imem_ack, halt_req,
    output imem_req, ir_load, pc_en, werf_out, wedmem_out, instr_done, halted, retired
  );
endinterface

// File: rtl/instr_sequencer.sv
// Fetch/execute sequencer: walks IDLE -> FETCH -> EXEC, stretches EXEC by
// wait_cycle extra cycles and only lets write strobes through on the final cycle.
module instr_sequencer (
  input  logic             clk,
  input  logic             rst_n,
  instr_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [15:0] retired_q, retired_d;

  logic imem_req, ir_load, pc_en, werf_out, wedmem_out, instr_done, halted;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= 2'd0;
      retired_q <= 16'h0000;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      retired_q <= retired_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    imem_req   = 1'b0;
    ir_load    = 1'b0;
    pc_en      = 1'b0;
    werf_out   = 1'b1;
    wedmem_out = 1'b1;
    instr_done = 1'b0;
    halted     = 1'b0;

    case (state_q)
      IDLE: begin
        halted = 1'b1;
        if (!bus.halt_req) state_d = FETCH;
      end
      FETCH: begin
        imem_req = 1'b1;
        if (bus.imem_ack) begin
          ir_load = 1'b1;
          cnt_d   = 2'd0;
          state_d = EXEC;
        end
      end
      EXEC: begin
        // Write strobes pass through only on the final cycle, so a stretched
        // instruction still produces a single write.
        if (cnt_q == bus.wait_cycle) begin
          pc_en      = 1'b1;
          werf_out   = bus.werf_in;
          wedmem_out = bus.wedmem_in;
          instr_done = 1'b1;
          cnt_d      = 2'd0;
          state_d    = bus.halt_req ? IDLE : FETCH;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 2'd0;
      end
    endcase

    retired_d = retired_q + {15'd0, instr_done};
  end

  assign bus.imem_req   = imem_req;
  assign bus.ir_load    = ir_load;
  assign bus.pc_en      = pc_en;
  assign bus.werf_out   = werf_out;
  assign bus.wedmem_out = wedmem_out;
  assign bus.instr_done = instr_done;
  assign bus.halted     = halted;
  assign bus.retired    = retired_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Bench for instr_sequencer: an instruction-level model checked every cycle,
// plus directed scenarios with hand-computed cycle positions and counts.
module tb_instr_sequencer;

  logic clk;
  logic rst_n;

  instr_sequencer_if bus ();

  instr_sequencer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: wait bound expired (t=%0t)", name, $time);
  endtask

  // Instruction-level model: fetching flag, exec cycles left, retire count
  bit          m_fetch;
  int          m_left;
  logic [15:0] m_ret;
  int          cyc;
  int          q_req[$], q_irl[$], q_pc[$], q_werf_lo[$], q_done[$];
  int          wed_lo_total;

  logic [22:0] act_v, exp_v;
  logic        e_halt, e_req, e_irl, e_pc, e_wf, e_wd, e_done;

  always @(negedge clk) begin
    act_v = {bus.halted, bus.imem_req, bus.ir_load, bus.pc_en,
             bus.werf_out, bus.wedmem_out, bus.instr_done, bus.retired};
    if (!rst_n) begin
      chk("reset_outputs", {9'd0, act_v}, {9'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000});
      m_fetch = 1'b0;
      m_left  = 0;
      m_ret   = 16'h0000;
      cyc     = 0;
      q_req.delete(); q_irl.delete(); q_pc.delete(); q_werf_lo.delete(); q_done.delete();
    end else begin
      e_halt = 1'b0; e_req = 1'b0; e_irl = 1'b0; e_pc = 1'b0;
      e_wf = 1'b1; e_wd = 1'b1; e_done = 1'b0;
      if (m_left > 0) begin
        if (m_left == 1) begin
          e_pc = 1'b1; e_wf = bus.werf_in; e_wd = bus.wedmem_in; e_done = 1'b1;
        end
      end else if (m_fetch) begin
        e_req = 1'b1;
        e_irl = bus.imem_ack;
      end else begin
        e_halt = 1'b1;
      end
      exp_v = {e_halt, e_req, e_irl, e_pc, e_wf, e_wd, e_done, m_ret};
      chk("cycle_outputs", {9'd0, act_v}, {9'd0, exp_v});

      if (bus.imem_req)    q_req.push_back(cyc);
      if (bus.ir_load)     q_irl.push_back(cyc);
      if (bus.pc_en)       q_pc.push_back(cyc);
      if (!bus.werf_out)   q_werf_lo.push_back(cyc);
      if (!bus.wedmem_out) wed_lo_total++;
      if (bus.instr_done)  q_done.push_back(cyc);

      if (m_left > 0) begin
        if (m_left == 1) begin
          m_ret   = m_ret + 16'd1;
          m_left  = 0;
          m_fetch = !bus.halt_req;
        end else begin
          m_left--;
        end
      end else if (m_fetch) begin
        if (bus.imem_ack) begin
          m_fetch = 1'b0;
          m_left  = int'(bus.wait_cycle) + 1;
        end
      end else begin
        m_fetch = !bus.halt_req;
      end
      cyc++;
    end
  end

  // Leaves the bench at posedge+1 just after reset release.
  task automatic do_reset(input bit h);
    @(posedge clk); #1;
    rst_n          = 1'b0;
    bus.halt_req   = h;
    bus.imem_ack   = 1'b0;
    bus.wait_cycle = 2'd0;
    bus.werf_in    = 1'b1;
    bus.wedmem_in  = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Called at posedge+1 with the sequencer in IDLE or FETCH; returns at
  // posedge+1 of the cycle after the final EXEC cycle.
  task automatic run_instr(input logic [1:0] w, input bit wf, input bit wd,
                           input int stall, input bit halt_after);
    int n;
    bus.wait_cycle = w;
    bus.werf_in    = wf;
    bus.wedmem_in  = wd;
    bus.halt_req   = 1'b0;
    bus.imem_ack   = 1'b0;
    n = 0;
    while (!bus.imem_req && n < 20) begin @(posedge clk); #1; n++; end
    if (n >= 20) timeout_fail("fetch_start");
    repeat (stall) begin @(posedge clk); #1; end
    bus.imem_ack = 1'b1;
    @(posedge clk); #1;
    bus.imem_ack = 1'b0;
    bus.halt_req = halt_after;
    n = 0;
    while (!bus.instr_done && n < 10) begin @(posedge clk); #1; n++; end
    if (n >= 10) timeout_fail("instr_done");
    @(posedge clk); #1;
  endtask

  initial begin
    int n;
    rst_n          = 1'b0;
    bus.halt_req   = 1'b1;
    bus.imem_ack   = 1'b0;
    bus.wait_cycle = 2'd0;
    bus.werf_in    = 1'b1;
    bus.wedmem_in  = 1'b1;
    wed_lo_total   = 0;

    // Single load-like instruction, wait_cycle=1, register write
    do_reset(1'b0);
    run_instr(2'd1, 1'b0, 1'b1, 0, 1'b1);
    repeat (2) @(posedge clk); #1;
    chk("s1_first_fetch_cycle", q_req[0], 1);
    chk("s1_pc_en_count", q_pc.size(), 1);
    chk("s1_pc_en_cycle", q_pc[0], 3);
    chk("s1_werf_lo_count", q_werf_lo.size(), 1);
    chk("s1_werf_lo_cycle", q_werf_lo[0], 3);
    chk("s1_retired", bus.retired, 16'd1);

    // Back-to-back wait_cycle 0, 2, 3
    do_reset(1'b1);
    run_instr(2'd0, 1'b1, 1'b1, 0, 1'b0);
    run_instr(2'd2, 1'b1, 1'b1, 0, 1'b0);
    run_instr(2'd3, 1'b1, 1'b1, 0, 1'b1);
    chk("s2_done_count", q_done.size(), 3);
    chk("s2_first_latency", q_done[0] - q_req[0] + 1, 2);
    chk("s2_gap_1", q_done[1] - q_done[0], 4);
    chk("s2_gap_2", q_done[2] - q_done[1], 5);
    chk("s2_retired", bus.retired, 16'd3);

    // Fetch stalled 3 cycles
    do_reset(1'b1);
    run_instr(2'd0, 1'b1, 1'b1, 3, 1'b1);
    chk("s3_fetch_cycles", q_req.size(), 4);
    chk("s3_ir_load_count", q_irl.size(), 1);
    chk("s3_ir_load_on_ack", q_irl[0], q_req[0] + 3);
    chk("s3_latency", q_done[0] - q_req[0] + 1, 5);

    // Halt raised mid-EXEC, then released
    do_reset(1'b1);
    run_instr(2'd2, 1'b0, 1'b1, 0, 1'b1);
    chk("s4_halted", bus.halted, 1'b1);
    chk("s4_no_req", bus.imem_req, 1'b0);
    chk("s4_retired", bus.retired, 16'd1);
    repeat (3) @(posedge clk); #1;
    chk("s4_still_halted", bus.halted, 1'b1);
    bus.halt_req = 1'b0;
    @(posedge clk); #1;
    chk("s4_resume_fetch", bus.imem_req, 1'b1);
    bus.halt_req = 1'b1;

    // Reset during the second EXEC cycle of a store
    do_reset(1'b1);
    wed_lo_total   = 0;
    bus.wait_cycle = 2'd1;
    bus.wedmem_in  = 1'b0;
    bus.werf_in    = 1'b1;
    bus.halt_req   = 1'b0;
    n = 0;
    while (!bus.imem_req && n < 20) begin @(posedge clk); #1; n++; end
    if (n >= 20) timeout_fail("s5_fetch_start");
    bus.imem_ack = 1'b1;
    @(posedge clk); #1;
    bus.imem_ack = 1'b0;
    bus.halt_req = 1'b1;
    @(posedge clk);
    rst_n = 1'b0;
    #1;
    chk("s5_wedmem_out_async", bus.wedmem_out, 1'b1);
    chk("s5_pc_en_async", bus.pc_en, 1'b0);
    chk("s5_done_async", bus.instr_done, 1'b0);
    chk("s5_halted_async", bus.halted, 1'b1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk); #1;
    chk("s5_wedmem_never_low", wed_lo_total, 0);
    chk("s5_retired", bus.retired, 16'd0);
    bus.wedmem_in = 1'b1;

    // Retire counter wrap after 65535 instructions
    do_reset(1'b1);
    bus.wait_cycle = 2'd0;
    bus.imem_ack   = 1'b1;
    bus.halt_req   = 1'b0;
    n = 0;
    while (q_done.size() < 65535 && n < 140000) begin @(posedge clk); n++; end
    #1;
    if (n >= 140000) timeout_fail("s6_65535_instructions");
    chk("s6_retired_ffff", bus.retired, 16'hFFFF);
    bus.halt_req = 1'b1;
    @(posedge clk); #1;
    chk("s6_final_done", bus.instr_done, 1'b1);
    @(posedge clk); #1;
    chk("s6_retired_wrap", bus.retired, 16'h0000);
    chk("s6_halted", bus.halted, 1'b1);
    bus.imem_ack = 1'b0;

    repeat (2) @(posedge clk); #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not complete (t=%0t)", $time);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/instr_sequencer.md
INSTR_SEQUENCER -- requirements
Module: instr_sequencer

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset.
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-004 SHALL have port wait_cycle, input, 2 bits: extra execute cycles for the current instruction, from the control unit.
REQ-005 SHALL have port werf_in, input, 1 bit: register-file write enable from the control unit, active-low.
REQ-006 SHALL have port wedmem_in, input, 1 bit: data-memory write enable from the control unit, active-low.
REQ-007 SHALL have port imem_ack, input, 1 bit: instruction word valid on the memory bus this cycle.
REQ-008 SHALL have port halt_req, input, 1 bit: request to stop at the next instruction boundary.
REQ-009 SHALL have port imem_req, output, 1 bit: instruction fetch request.
REQ-010 SHALL have port ir_load, output, 1 bit: load the instruction register.
REQ-011 SHALL have port pc_en, output, 1 bit: update the PC with the muxpc selection.
REQ-012 SHALL have port werf_out, output, 1 bit: gated register-file write enable, active-low.
REQ-013 SHALL have port wedmem_out, output, 1 bit: gated data-memory write enable, active-low.
REQ-014 SHALL have port instr_done, output, 1 bit: one-cycle pulse when an instruction retires.
REQ-015 SHALL have port halted, output, 1 bit: sequencer is in IDLE.
REQ-016 SHALL have port retired, output, 16 bits: count of retired instructions.

Function
REQ-017 SHALL implement exactly three states: IDLE, FETCH, EXEC, plus a 2-bit execute counter cnt.
REQ-018 IDLE: halted=1 and all other strobes inactive; when halt_req=0, go to FETCH next cycle, otherwise stay in IDLE.
REQ-019 FETCH: imem_req=1; if imem_ack=0, stay in FETCH with ir_load=0; if imem_ack=1, ir_load=1 in the same cycle (combinational) and go to EXEC with cnt=0.
REQ-020 SHALL ignore halt_req while in FETCH and EXEC; a fetched instruction always completes.
REQ-021 EXEC, cnt!=wait_cycle: cnt increments by 1; pc_en=0; werf_out=1 and wedmem_out=1.
REQ-022 EXEC, cnt==wait_cycle (final cycle): pc_en=1, werf_out=werf_in, wedmem_out=wedmem_in, instr_done=1; go to IDLE if halt_req=1, otherwise go to FETCH.
REQ-023 SHALL compare wait_cycle combinationally each EXEC cycle; wait_cycle is stable while the IR is held.
REQ-024 Instruction latency, fetch cycle through final cycle inclusive, SHALL be 2 + wait_cycle cycles with zero-wait imem_ack: 2, 3, 4 or 5 cycles for wait_cycle = 0, 1, 2, 3.
REQ-025 werf_out and wedmem_out SHALL be 1 outside the final EXEC cycle, so each instruction produces at most one write strobe.
REQ-026 imem_req, ir_load, pc_en and instr_done SHALL be 0 in any state not listed above as asserting them.
REQ-027 retired SHALL increment by 1 on each cycle with instr_done=1, wrapping from 16'hFFFF to 16'h0000.
REQ-028 Back-to-back operation: a final EXEC cycle SHALL be followed immediately by FETCH, with no bubble.

Reset
REQ-029 While rst_n=0, outputs SHALL be: state=IDLE, cnt=0, halted=1, imem_req=0, ir_load=0, pc_en=0, werf_out=1, wedmem_out=1, instr_done=0, retired=0.
REQ-030 Reset asserted mid-EXEC SHALL force all outputs to their reset values immediately, without waiting for a clock edge; the interrupted instruction SHALL produce no pc_en or write strobe and SHALL NOT be counted.
REQ-031 After rst_n deasserts, the first FETCH SHALL occur on the first edge at which halt_req=0.

Verification
REQ-032 Bench SHALL cover: reset release, halt_req=0, imem_ack=1, wait_cycle=1, werf_in=0 -> imem_req at cycle 1; werf_out=0 and pc_en=1 only at cycle 3; retired=1.
REQ-033 Bench SHALL cover: wait_cycle sequence 0, 2, 3 back-to-back with zero-wait ack -> instr_done pulses 2, 4 and 5 cycles apart; retired=3.
REQ-034 Bench SHALL cover: imem_ack held low for 3 cycles in FETCH -> ir_load stays 0 and the state holds; total latency for wait_cycle=0 is 5 cycles.
REQ-035 Bench SHALL cover: halt_req=1 asserted mid-EXEC -> the instruction completes, then halted=1 and imem_req=0; deasserting halt_req -> FETCH resumes the next cycle.
REQ-036 Bench SHALL cover: rst_n pulled low during the second EXEC cycle of a store (wedmem_in=0, wait_cycle=1) -> wedmem_out never goes 0, retired=0.
REQ-037 Bench SHALL cover: retired preloaded to 16'hFFFF via 65535 instructions -> the next instruction wraps retired to 16'h0000.
